// File: rtl/pwm_shadow_regbank_pkg.sv
// Shared types and widths for the PWM shadow/active register bank.
// Optional build macro: PWM_SHADOW_LOCK_EN (adds a load-inhibit lock input).
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

package pwm_shadow_regbank_pkg;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } _pwm_onoff;

    typedef enum logic [1:0] {
        LOAD_ZERO      = 2'd0,
        LOAD_TOP       = 2'd1,
        LOAD_BOTH      = 2'd2,
        LOAD_IMMEDIATE = 2'd3
    } _load_mode;

    localparam int unsigned PWM_WIDTH = `PWMCOUNT_WIDTH;
    localparam int unsigned NCH_DEF   = 8;
    localparam int unsigned DIVW_DEF  = 4;

    // Channel-index width; a single-channel bank still gets a 1-bit index.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_shadow_regbank_if.sv
// Register-file write bus into the shadow bank.
interface pwm_shadow_regbank_if
    import pwm_shadow_regbank_pkg::*;
#(
    parameter int unsigned NCH   = NCH_DEF,
    parameter int unsigned WIDTH = PWM_WIDTH
);
    localparam int unsigned CHW = ch_width(NCH);

    logic             wr_en;
    logic [CHW-1:0]   wr_ch;
    logic [WIDTH-1:0] wr_data;

    modport master (output wr_en, output wr_ch, output wr_data);
    modport slave  (input  wr_en, input  wr_ch, input  wr_data);
endinterface

// File: rtl/pwm_shadow_regbank_channel.sv
// One channel: shadow register, active register and pending flag.
module pwm_shadow_channel #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_on,
    input  logic             wr_hit,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             load,
    output logic [WIDTH-1:0] shadow,
    output logic [WIDTH-1:0] active,
    output logic             pending
);

    // Shadow capture, active transfer and pending tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (wr_hit) begin
                shadow <= wr_data;
            end
            if (!pwm_on) begin
                // PWM stopped: comparators follow the shadow directly.
                active  <= shadow;
                pending <= 1'b0;
            end else begin
                if (load && pending) begin
                    active <= shadow;
                end
                // A write landing with a load keeps the channel pending.
                if (wr_hit) begin
                    pending <= 1'b1;
                end else if (load) begin
                    pending <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_shadow_regbank.sv
// Multi-channel double-buffered PWM compare/period bank with event-aligned loads.
// Optional build macro: PWM_SHADOW_LOCK_EN adds input 'lock' that inhibits
// event/immediate loads and freezes the divider while high.
module pwm_shadow_regbank
    import pwm_shadow_regbank_pkg::*;
#(
    parameter int unsigned NCH   = NCH_DEF,
    parameter int unsigned WIDTH = PWM_WIDTH,
    parameter int unsigned DIVW  = DIVW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  _pwm_onoff            pwm_onoff,
    input  logic                 evt_zero,
    input  logic                 evt_top,
    input  _load_mode            load_mode,
    input  logic [DIVW-1:0]      evt_div,
`ifdef PWM_SHADOW_LOCK_EN
    input  logic                 lock,
`endif
    pwm_shadow_regbank_if.slave  wr,
    input  logic                 force_load,
    output logic [NCH*WIDTH-1:0] shadow_out,
    output logic [NCH*WIDTH-1:0] active_out,
    output logic [NCH-1:0]       pending,
    output logic                 load_pulse
);

    localparam int unsigned CHW = ch_width(NCH);

    logic            pwm_on;
    logic            qev;
    logic            any_pend;
    logic            lock_c;
    logic            load_now;
    logic [DIVW-1:0] div_cnt;
    logic [DIVW-1:0] div_next;

    assign pwm_on   = (pwm_onoff == PWM_ON);
    assign any_pend = |pending;

`ifdef PWM_SHADOW_LOCK_EN
    assign lock_c = lock;
`else
    assign lock_c = 1'b0;
`endif

    // Qualifying event for the selected load mode; coincident strobes count once.
    always_comb begin
        qev = 1'b0;
        unique case (load_mode)
            LOAD_ZERO:      qev = evt_zero;
            LOAD_TOP:       qev = evt_top;
            LOAD_BOTH:      qev = evt_zero | evt_top;
            LOAD_IMMEDIATE: qev = 1'b0;
            default:        qev = 1'b0;
        endcase
    end

    // Load decision and divider next value.
    always_comb begin
        load_now = 1'b0;
        div_next = div_cnt;
        if (!pwm_on) begin
            div_next = '0;
        end else if (force_load) begin
            load_now = 1'b1;
            div_next = '0;
        end else if (lock_c) begin
            div_next = div_cnt;
        end else if (load_mode == LOAD_IMMEDIATE) begin
            load_now = any_pend;
            div_next = '0;
        end else if (qev) begin
            // >= also covers evt_div lowered beneath the running count.
            if (div_cnt >= evt_div) begin
                load_now = 1'b1;
                div_next = '0;
            end else begin
                div_next = div_cnt + DIVW'(1);
            end
        end
    end

    // Divider state and load strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            load_pulse <= 1'b0;
        end else begin
            div_cnt    <= div_next;
            load_pulse <= pwm_on && load_now && any_pend;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_shadow_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .pwm_on  (pwm_on),
            .wr_hit  (wr.wr_en && (wr.wr_ch == CHW'(i))),
            .wr_data (wr.wr_data),
            .load    (load_now),
            .shadow  (shadow_out[i*WIDTH +: WIDTH]),
            .active  (active_out[i*WIDTH +: WIDTH]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_pwm_shadow_regbank.sv
// Self-checking bench for pwm_shadow_regbank: directed scenarios plus random
// traffic against a behavioural array model of the bank.
module tb_pwm_shadow_regbank;
    import pwm_shadow_regbank_pkg::*;

    localparam int unsigned NCH   = 8;
    localparam int unsigned WIDTH = PWM_WIDTH;
    localparam int unsigned DIVW  = 4;
    localparam int unsigned VW    = NCH * WIDTH;

    logic                 clk;
    logic                 reset;
    _pwm_onoff            pwm_onoff;
    logic                 evt_zero;
    logic                 evt_top;
    _load_mode            load_mode;
    logic [DIVW-1:0]      evt_div;
    logic                 lk;
    logic                 force_load;
    logic [NCH*WIDTH-1:0] shadow_out;
    logic [NCH*WIDTH-1:0] active_out;
    logic [NCH-1:0]       pending;
    logic                 load_pulse;

    pwm_shadow_regbank_if #(.NCH(NCH), .WIDTH(WIDTH)) wr_bus ();

    pwm_shadow_regbank #(.NCH(NCH), .WIDTH(WIDTH), .DIVW(DIVW)) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_onoff  (pwm_onoff),
        .evt_zero   (evt_zero),
        .evt_top    (evt_top),
        .load_mode  (load_mode),
        .evt_div    (evt_div),
`ifdef PWM_SHADOW_LOCK_EN
        .lock       (lk),
`endif
        .wr         (wr_bus),
        .force_load (force_load),
        .shadow_out (shadow_out),
        .active_out (active_out),
        .pending    (pending),
        .load_pulse (load_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model: per-channel arrays plus an integer event counter.
    logic [WIDTH-1:0] m_shadow [NCH];
    logic [WIDTH-1:0] m_active [NCH];
    bit               m_pend   [NCH];
    int               m_div;
    bit               m_pulse;

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
            m_pend[i]   = 1'b0;
        end
        m_div   = 0;
        m_pulse = 1'b0;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    function automatic void model_step();
        bit fire;
        bit any;
        bit ev;
        int ch;
        if (reset) begin
            model_reset();
            return;
        end
        ch   = int'(wr_bus.wr_ch);
        fire = 1'b0;
        any  = 1'b0;
        for (int i = 0; i < NCH; i++) any |= m_pend[i];
        if (pwm_onoff == PWM_OFF) begin
            for (int i = 0; i < NCH; i++) begin
                m_active[i] = m_shadow[i];
                m_pend[i]   = 1'b0;
            end
            m_div   = 0;
            m_pulse = 1'b0;
            if (wr_bus.wr_en && ch < NCH) m_shadow[ch] = wr_bus.wr_data;
            return;
        end
        case (load_mode)
            LOAD_ZERO: ev = evt_zero;
            LOAD_TOP:  ev = evt_top;
            LOAD_BOTH: ev = evt_zero || evt_top;
            default:   ev = 1'b0;
        endcase
        if (force_load) begin
            fire  = 1'b1;
            m_div = 0;
        end else if (lk) begin
            fire = 1'b0;
        end else if (load_mode == LOAD_IMMEDIATE) begin
            fire  = any;
            m_div = 0;
        end else if (ev) begin
            if (m_div >= int'(evt_div)) begin
                fire  = 1'b1;
                m_div = 0;
            end else begin
                m_div++;
            end
        end
        m_pulse = fire && any;
        if (fire) begin
            for (int i = 0; i < NCH; i++) begin
                if (m_pend[i]) begin
                    m_active[i] = m_shadow[i];
                    m_pend[i]   = 1'b0;
                end
            end
        end
        if (wr_bus.wr_en && ch < NCH) begin
            m_shadow[ch] = wr_bus.wr_data;
            m_pend[ch]   = 1'b1;
        end
    endfunction

    task automatic compare_all();
        logic [VW-1:0]  es;
        logic [VW-1:0]  ea;
        logic [NCH-1:0] ep;
        for (int i = 0; i < NCH; i++) begin
            es[i*WIDTH +: WIDTH] = m_shadow[i];
            ea[i*WIDTH +: WIDTH] = m_active[i];
            ep[i]                = m_pend[i];
        end
        check("shadow_out", shadow_out, es);
        check("active_out", active_out, ea);
        check("pending", VW'(pending), VW'(ep));
        check("load_pulse", VW'(load_pulse), VW'(m_pulse));
    endtask

    // One clock: model, edge, sample 1 time unit after the edge.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [WIDTH-1:0] act_ch(input int i);
        return active_out[i*WIDTH +: WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] sh_ch(input int i);
        return shadow_out[i*WIDTH +: WIDTH];
    endfunction

    task automatic idle();
        evt_zero       = 1'b0;
        evt_top        = 1'b0;
        force_load     = 1'b0;
        wr_bus.wr_en   = 1'b0;
        wr_bus.wr_ch   = '0;
        wr_bus.wr_data = '0;
    endtask

    task automatic write(input int ch, input logic [WIDTH-1:0] d);
        wr_bus.wr_en   = 1'b1;
        wr_bus.wr_ch   = 3'(ch);
        wr_bus.wr_data = d;
    endtask

    initial begin
        reset     = 1'b1;
        pwm_onoff = PWM_ON;
        load_mode = LOAD_ZERO;
        evt_div   = '0;
        lk        = 1'b0;
        idle();
        model_reset();
        #3;
        check("rst_active", active_out, '0);
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset in the middle of an update.
        write(3, 16'h1234);
        step();
        idle();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_mid_shadow", shadow_out, '0);
        check("rst_mid_pending", VW'(pending), '0);
        step();
        reset = 1'b0;
        step();
        check("rst_rel_pending", VW'(pending), '0);

        // LOAD_ZERO with a divide-by-3 event divider.
        load_mode = LOAD_ZERO;
        evt_div   = 4'd2;
        write(0, 16'h0100);
        step();
        idle();
        evt_zero = 1'b1;
        step();
        check("div_ev1_ch0", VW'(act_ch(0)), '0);
        step();
        check("div_ev2_ch0", VW'(act_ch(0)), '0);
        step();
        check("div_ev3_ch0", VW'(act_ch(0)), VW'(16'h0100));
        check("div_ev3_pulse", VW'(load_pulse), VW'(1'b1));
        check("div_ev3_pend0", VW'(pending[0]), '0);
        evt_zero = 1'b0;
        step();
        check("div_pulse_drop", VW'(load_pulse), '0);

        // LOAD_BOTH: coincident strobes give a single load.
        load_mode = LOAD_BOTH;
        evt_div   = 4'd0;
        write(1, 16'h0011);
        step();
        idle();
        evt_zero = 1'b1;
        evt_top  = 1'b1;
        step();
        check("both_ch1", VW'(act_ch(1)), VW'(16'h0011));
        check("both_pulse", VW'(load_pulse), VW'(1'b1));
        idle();
        step();
        check("both_pulse_once", VW'(load_pulse), '0);
        evt_top = 1'b1;
        step();
        check("top_nopend_pulse", VW'(load_pulse), '0);
        idle();

        // Write colliding with a load on the same channel.
        load_mode = LOAD_ZERO;
        write(2, 16'h0055);
        step();
        write(2, 16'h00AA);
        evt_zero = 1'b1;
        step();
        check("coll_active", VW'(act_ch(2)), VW'(16'h0055));
        check("coll_shadow", VW'(sh_ch(2)), VW'(16'h00AA));
        check("coll_pend", VW'(pending[2]), VW'(1'b1));
        idle();

        // PWM off: transparent update, then divider restarts from zero.
        pwm_onoff = PWM_OFF;
        write(7, 16'hFFFF);
        step();
        idle();
        step();
        check("off_ch7", VW'(act_ch(7)), VW'(16'hFFFF));
        check("off_pend7", VW'(pending[7]), '0);
        pwm_onoff = PWM_ON;
        evt_div   = 4'd1;
        write(6, 16'h0077);
        step();
        idle();
        evt_zero = 1'b1;
        step();
        check("on_ev1_ch6", VW'(act_ch(6)), '0);
        check("on_ev1_pulse", VW'(load_pulse), '0);
        step();
        check("on_ev2_ch6", VW'(act_ch(6)), VW'(16'h0077));
        idle();

        // LOAD_IMMEDIATE: two clocks from write strobe to active.
        load_mode = LOAD_IMMEDIATE;
        write(5, 16'h0042);
        step();
        check("imm_ch5_early", VW'(act_ch(5)), '0);
        idle();
        step();
        check("imm_ch5", VW'(act_ch(5)), VW'(16'h0042));

`ifdef PWM_SHADOW_LOCK_EN
        // Lock holds loads off until released or forced.
        lk = 1'b1;
        write(4, 16'h0099);
        step();
        idle();
        for (int k = 0; k < 3; k++) step();
        check("lock_hold_ch4", VW'(act_ch(4)), '0);
        lk = 1'b0;
        step();
        step();
        check("lock_rel_ch4", VW'(act_ch(4)), VW'(16'h0099));
        lk = 1'b1;
        write(4, 16'h0098);
        step();
        idle();
        force_load = 1'b1;
        step();
        check("lock_force_ch4", VW'(act_ch(4)), VW'(16'h0098));
        idle();
        lk = 1'b0;
`endif

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 39) == 0)
                pwm_onoff = (pwm_onoff == PWM_ON) ? PWM_OFF : PWM_ON;
            if ($urandom_range(0, 29) == 0) load_mode = _load_mode'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) evt_div = DIVW'($urandom_range(0, 3));
`ifdef PWM_SHADOW_LOCK_EN
            if ($urandom_range(0, 19) == 0) lk = ~lk;
`endif
            evt_zero       = ($urandom_range(0, 3) == 0);
            evt_top        = ($urandom_range(0, 3) == 0);
            force_load     = ($urandom_range(0, 49) == 0);
            wr_bus.wr_en   = ($urandom_range(0, 2) == 0);
            wr_bus.wr_ch   = 3'($urandom_range(0, NCH - 1));
            wr_bus.wr_data = WIDTH'($urandom);
            step();
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
